// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// request-decode helpers.
package lsu_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) ||
           ((f3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: selects byte/half/word from the low end of the read
// word and sign- or zero-extends it according to funct3.
module lsu_load_ext
  import lsu_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  output logic [31:0] load_data_c
);

  // Extend the addressed low-order field to 32 bits.
  always_comb begin
    load_data_c = '0;
    case (funct3)
      F3_B:    load_data_c = {{24{word[7]}}, word[7:0]};
      F3_H:    load_data_c = {{16{word[15]}}, word[15:0]};
      F3_W:    load_data_c = word;
      F3_BU:   load_data_c = {24'd0, word[7:0]};
      F3_HU:   load_data_c = {16'd0, word[15:0]};
      default: load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and a word-write DMEM. Loads are a word
// read plus extract; SB/SH are read-modify-write; SW writes directly.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/HU/W accesses return
// rsp_err instead of being performed.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dmem_sel,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_out
);

  localparam logic [31:0] ADDR_MAX = 32'(MEM_DEPTH - 4);

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rd_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic        rsp_valid_d, rsp_err_d;
  logic [31:0] rsp_rdata_d;
  logic        accept_c, req_err_c, mis_c;
  logic [31:0] load_data_c;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept_c  = req_valid && req_ready;
  assign dmem_sel  = (state_q == ST_WRITE) && !rst;
  assign dmem_addr = addr_q;

`ifdef MISALIGN_TRAP_EN
  assign mis_c = misaligned(req_funct3, req_addr[1:0]);
`else
  assign mis_c = 1'b0;
`endif

  // Address compare on the full 32 bits also catches addr+3 wrapping.
  assign req_err_c = !f3_legal(req_we, req_funct3) || (req_addr > ADDR_MAX) || mis_c;

  lsu_load_ext u_load_ext (
    .funct3      (f3_q),
    .word        (dmem_out),
    .load_data_c (load_data_c)
  );

  // Merge the store byte/half into the previously read word.
  always_comb begin
    dmem_wdata = wdata_q;
    case (f3_q)
      F3_B:    dmem_wdata = {rd_q[31:8], wdata_q[7:0]};
      F3_H:    dmem_wdata = {rd_q[31:16], wdata_q[15:0]};
      default: dmem_wdata = wdata_q;
    endcase
  end

  // Next-state and response decode.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (req_err_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (we_q) begin
          state_d = ST_WRITE;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data_c;
          rsp_err_d   = 1'b0;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      if (accept_c) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
        f3_q    <= req_funct3;
      end
      if (state_q == ST_READ) rd_q <= dmem_out;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a byte-array DMEM driven by the DUT and an
// independent reference memory that produces expected responses.
module tb_lsu_ctrl;

  localparam int unsigned MEM_DEPTH = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
    int          acc;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, dmem_sel;
  logic [31:0] rsp_rdata, dmem_addr, dmem_wdata, dmem_out;

  logic [7:0]  mem [MEM_DEPTH];
  logic [7:0]  mm  [MEM_DEPTH];
  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          wr_cnt = 0;

  lsu_ctrl #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dmem_sel   (dmem_sel),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_out   (dmem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign dmem_out = (dmem_addr <= 32'(MEM_DEPTH - 4)) ?
                    {mem[dmem_addr + 3], mem[dmem_addr + 2], mem[dmem_addr + 1], mem[dmem_addr]} : 32'd0;

  always @(posedge clk) begin
    if (dmem_sel && dmem_addr <= 32'(MEM_DEPTH - 4)) begin
      mem[dmem_addr]     = dmem_wdata[7:0];
      mem[dmem_addr + 1] = dmem_wdata[15:8];
      mem[dmem_addr + 2] = dmem_wdata[23:16];
      mem[dmem_addr + 3] = dmem_wdata[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mm[a + 3], mm[a + 2], mm[a + 1], mm[a]};
  endfunction

  // Response monitor: counts writes and checks every rsp_valid against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (dmem_sel) wr_cnt++;
    if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
        chk({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
        chk({e.tag, "_writes"}, 32'(wr_cnt), 32'(e.wr));
      end
      wr_cnt = 0;
    end
  end

  task automatic send(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input bit track);
    exp_t e;
    logic legal, mis;
    logic [31:0] w;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                 : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
`endif
      e.tag = tag; e.acc = cyc; e.rdata = 32'd0; e.err = 1'b0; e.wr = 0;
      if (!legal || addr > 32'(MEM_DEPTH - 4) || mis) begin
        e.err = 1'b1; e.lat = 1;
      end else if (!we) begin
        w = mword(addr);
        e.lat = 2;
        case (f3)
          3'd0: e.rdata = {{24{w[7]}}, w[7:0]};
          3'd1: e.rdata = {{16{w[15]}}, w[15:0]};
          3'd2: e.rdata = w;
          3'd4: e.rdata = {24'd0, w[7:0]};
          default: e.rdata = {16'd0, w[15:0]};
        endcase
      end else begin
        e.wr = 1;
        e.lat = (f3 == 3'd2) ? 2 : 3;
        mm[addr] = wd[7:0];
        if (f3 != 3'd0) mm[addr + 1] = wd[15:8];
        if (f3 == 3'd2) begin mm[addr + 2] = wd[23:16]; mm[addr + 3] = wd[31:24]; end
      end
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (track) begin
      n = 0;
      while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
      if (q.size() != 0) begin
        chk({tag, "_rsp_timeout"}, 32'(q.size()), 32'd0);
        q.delete();
      end
    end
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] raddr;
    for (int i = 0; i < MEM_DEPTH; i++) begin mem[i] = 8'h00; mm[i] = 8'h00; end
    mem[0] = 8'h80; mem[1] = 8'hFF; mem[2] = 8'h34; mem[3] = 8'h12;
    mem[4] = 8'h78; mem[5] = 8'h56; mem[6] = 8'h9A; mem[7] = 8'h3C;
    for (int i = 0; i < 8; i++) mm[i] = mem[i];
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_dmem_sel", 32'(dmem_sel), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);

    send("lb0",  1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    send("lbu0", 1'b0, 3'd4, 32'd0, 32'd0, 1'b1);
    send("lh0",  1'b0, 3'd1, 32'd0, 32'd0, 1'b1);
    send("lhu0", 1'b0, 3'd5, 32'd0, 32'd0, 1'b1);
    send("lw0",  1'b0, 3'd2, 32'd0, 32'd0, 1'b1);
    send("lb7",  1'b0, 3'd0, 32'd7, 32'd0, 1'b1);
    send("sb0",  1'b1, 3'd0, 32'd0, 32'hAABBCCDD, 1'b1);
    send("lw0b", 1'b0, 3'd2, 32'd0, 32'd0, 1'b1);
    send("sh4",  1'b1, 3'd1, 32'd4, 32'h1234BEEF, 1'b1);
    send("lw4",  1'b0, 3'd2, 32'd4, 32'd0, 1'b1);
    send("swtop", 1'b1, 3'd2, 32'(MEM_DEPTH - 4), 32'hDEADBEEF, 1'b1);
    send("lwtop", 1'b0, 3'd2, 32'(MEM_DEPTH - 4), 32'd0, 1'b1);
    send("lwoor", 1'b0, 3'd2, 32'(MEM_DEPTH - 3), 32'd0, 1'b1);
    send("swoor", 1'b1, 3'd2, 32'(MEM_DEPTH), 32'h11111111, 1'b1);
    send("lwwrap", 1'b0, 3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1);
    send("ld011", 1'b0, 3'd3, 32'd0, 32'd0, 1'b1);
    send("st100", 1'b1, 3'd4, 32'd0, 32'h55555555, 1'b1);
    send("lw1",  1'b0, 3'd2, 32'd1, 32'd0, 1'b1);
    send("sh1",  1'b1, 3'd1, 32'd1, 32'h0000A5A5, 1'b1);
    send("lw0c", 1'b0, 3'd2, 32'd0, 32'd0, 1'b1);

    // Reset while the SB is in its WRITE cycle: no write and no response.
    send("abort", 1'b1, 3'd0, 32'd8, 32'h000000EE, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort_sel", 32'(dmem_sel), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    wr_cnt = 0;
    send("abort_lw8", 1'b0, 3'd2, 32'd8, 32'd0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      raddr = 32'($urandom_range(0, MEM_DEPTH + 4));
      send("rnd", 1'($urandom_range(0, 1)), rf3, raddr, $urandom, 1'b1);
    end
    for (int i = 0; i < 16; i++) send("rdback", 1'b0, 3'd2, 32'(i * 4), 32'd0, 1'b1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
